// File: rtl/div_issue_queue.sv
// div_issue_queue: in-order request FIFO feeding an iterative divider, with a
// registered single-port writeback stage and pipeline flush.
// Optional build macro DIV_FASTPATH_EN resolves divide-by-zero and signed
// overflow locally without occupying the divider.
module div_issue_queue #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [1:0]            req_op_i,
  input  logic [5:0]            req_dest_i,
  input  logic [2:0]            req_ticket_i,
  input  logic [DATA_WIDTH-1:0] req_a_i,
  input  logic [DATA_WIDTH-1:0] req_b_i,
  input  logic                  flush_i,
  output logic                  div_enable_o,
  output logic [1:0]            div_op_type_o,
  output logic [5:0]            div_destination_o,
  output logic [2:0]            div_ticket_o,
  output logic [DATA_WIDTH-1:0] div_dividend_o,
  output logic [DATA_WIDTH-1:0] div_divider_o,
  input  logic                  div_ready_i,
  input  logic                  div_valid_i,
  input  logic [5:0]            div_destination_i,
  input  logic [2:0]            div_ticket_i,
  input  logic [DATA_WIDTH-1:0] div_result_i,
  output logic                  wb_valid_o,
  output logic [5:0]            wb_destination_o,
  output logic [2:0]            wb_ticket_o,
  output logic [DATA_WIDTH-1:0] wb_result_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  logic [1:0]            r_op     [DEPTH];
  logic [5:0]            r_dest   [DEPTH];
  logic [2:0]            r_ticket [DEPTH];
  logic [DATA_WIDTH-1:0] r_a      [DEPTH];
  logic [DATA_WIDTH-1:0] r_b      [DEPTH];

  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW:0]           r_count;
  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_drop;

  logic                  w_not_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_dispatch;
  logic                  w_fast;
  logic                  w_fast_hit;
  logic [DATA_WIDTH-1:0] w_fast_result;

  assign w_not_empty       = (r_count != '0);
  assign req_ready_o       = (r_count != (PW+1)'(DEPTH));
  assign w_push            = req_valid_i & req_ready_o & ~flush_i;
  assign w_pop             = w_dispatch | w_fast;

  assign div_op_type_o     = r_op[r_rd_ptr];
  assign div_destination_o = r_dest[r_rd_ptr];
  assign div_ticket_o      = r_ticket[r_rd_ptr];
  assign div_dividend_o    = r_a[r_rd_ptr];
  assign div_divider_o     = r_b[r_rd_ptr];
  assign div_enable_o      = w_dispatch;

`ifdef DIV_FASTPATH_EN
  localparam logic [DATA_WIDTH-1:0] INT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Classify the head as a locally-resolvable special case
  always_comb begin
    w_fast_hit    = 1'b0;
    w_fast_result = '0;
    if (div_divider_o == '0) begin
      w_fast_hit    = 1'b1;
      w_fast_result = div_op_type_o[1] ? div_dividend_o : '1;
    end else if (!div_op_type_o[0] && (div_dividend_o == INT_MIN) && (div_divider_o == '1)) begin
      w_fast_hit    = 1'b1;
      w_fast_result = div_op_type_o[1] ? '0 : INT_MIN;
    end
  end
`else
  assign w_fast_hit    = 1'b0;
  assign w_fast_result = '0;
`endif

  // Issue FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Issue FSM next-state and launch decision
  always_comb begin
    w_state_nxt = r_state;
    w_dispatch  = 1'b0;
    w_fast      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_not_empty && !flush_i) begin
          if (w_fast_hit) begin
            w_fast = 1'b1;
          end else if (div_ready_i) begin
            w_dispatch  = 1'b1;
            w_state_nxt = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (div_valid_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FIFO pointers and occupancy; flush empties and overrides any push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO payload storage
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_op[r_wr_ptr]     <= req_op_i;
      r_dest[r_wr_ptr]   <= req_dest_i;
      r_ticket[r_wr_ptr] <= req_ticket_i;
      r_a[r_wr_ptr]      <= req_a_i;
      r_b[r_wr_ptr]      <= req_b_i;
    end
  end

  // Writeback register and drop flag for results orphaned by a flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop           <= 1'b0;
      wb_valid_o       <= 1'b0;
      wb_destination_o <= '0;
      wb_ticket_o      <= '0;
      wb_result_o      <= '0;
    end else begin
      wb_valid_o <= 1'b0;
      if (w_fast) begin
        wb_valid_o       <= 1'b1;
        wb_destination_o <= div_destination_o;
        wb_ticket_o      <= div_ticket_o;
        wb_result_o      <= w_fast_result;
      end
      if (r_state == S_BUSY) begin
        if (div_valid_i) begin
          r_drop <= 1'b0;
          if (!r_drop && !flush_i) begin
            wb_valid_o       <= 1'b1;
            wb_destination_o <= div_destination_i;
            wb_ticket_o      <= div_ticket_i;
            wb_result_o      <= div_result_i;
          end
        end else if (flush_i) begin
          r_drop <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/div_issue_queue.md
Name: div_issue_queue

Overview:
- Issue buffer and writeback stage that sits directly upstream and downstream of the scalar iterative divider.
- Accepts divide/remainder requests from the dispatch stage into a small in-order FIFO.
- Launches one operation at a time into the divider using its enable/ready protocol.
- Registers the divider's result onto a single writeback port. Supports pipeline flush.

Parameters:
DATA_WIDTH, 32, operand/result width
DEPTH, 4, FIFO entries; power of two, >=2

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid_i  input  1  request present
req_ready_o  output  1  FIFO can accept
req_op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
req_dest_i  input  6  destination tag
req_ticket_i  input  3  ROB ticket
req_a_i  input  DATA_WIDTH  dividend
req_b_i  input  DATA_WIDTH  divisor
flush_i  input  1  discard queued and in-flight work
div_enable_o  output  1  one-cycle start pulse to divider
div_op_type_o  output  2  head op
div_destination_o  output  6  head tag
div_ticket_o  output  3  head ticket
div_dividend_o  output  DATA_WIDTH  head dividend
div_divider_o  output  DATA_WIDTH  head divisor
div_ready_i  input  1  divider idle
div_valid_i  input  1  divider result valid (one-cycle pulse)
div_destination_i  input  6  divider result tag
div_ticket_i  input  3  divider result ticket
div_result_i  input  DATA_WIDTH  divider result
wb_valid_o  output  1  writeback valid (one-cycle pulse)
wb_destination_o  output  6  writeback tag
wb_ticket_o  output  3  writeback ticket
wb_result_o  output  DATA_WIDTH  writeback data

Behaviour:
- Single clock clk; asynchronous active-low reset rst_n.
- Reset: FIFO empty (pointers and count 0), state IDLE, drop flag 0, wb_valid_o 0, wb_destination_o/wb_ticket_o/wb_result_o 0. div_enable_o is 0 while rst_n is low.
- Reset asserted mid-operation abandons all state. Any later div_valid_i pulse for the abandoned operation, arriving in IDLE, is ignored.
- Push: on req_valid_i & req_ready_o & !flush_i, write {op,dest,ticket,a,b} at the tail.
- req_ready_o = (count != DEPTH), derived combinationally from count only. There is no same-cycle push-when-full bypass, even if a pop occurs.
- div_* payload outputs always show the FIFO head, combinationally.
- FSM IDLE:
  - Dispatch when count != 0, div_ready_i = 1 and flush_i = 0.
  - Dispatch asserts div_enable_o for exactly that cycle, pops the head and moves to BUSY.
- FSM BUSY:
  - div_enable_o stays 0.
  - On div_valid_i, return to IDLE. A new dispatch is allowed in the very next cycle.
- At most one operation is outstanding, so div_enable_o never pulses in two consecutive cycles.
- Writeback register:
  - On div_valid_i in BUSY with drop flag = 0, capture div_destination_i, div_ticket_i and div_result_i, and pulse wb_valid_o the following cycle.
  - Latency from div_valid_i to wb_valid_o is 1 cycle.
  - wb_valid_o is otherwise 0; wb data holds its last value.
- Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- flush_i:
  - Next edge: empty the FIFO and ignore any same-cycle push.
  - Suppress dispatch in the flush cycle.
  - If BUSY (or the flush coincides with div_valid_i), do not write that result back; its wb_valid_o is 0.
  - If BUSY and no div_valid_i in the flush cycle, set the drop flag. The FSM stays BUSY until div_valid_i, then clears the drop flag without writeback.
- Tags and ticket pass through unmodified. No operand arithmetic occurs except in the optional feature.

Optional Feature:
- Macro: DIV_FASTPATH_EN.
- When defined, in IDLE with count != 0 and flush_i = 0, the head is checked for the special cases below. If one applies, it is popped without asserting div_enable_o and without requiring div_ready_i. Its result is written to the wb register next cycle, and the FSM stays IDLE.
  - Divisor 0: DIV/DIVU -> all ones; REM/REMU -> dividend.
  - Signed overflow (op 00/10, dividend = 0x80000000, divisor = 0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- One fast-path pop per cycle. Back-to-back fast-path ops produce consecutive wb_valid_o pulses.
- When not defined, every request goes to the divider.

Test Plan:
- Reset, then one DIVU 100/7 dest 5 ticket 2 -> single div_enable_o pulse with head fields; divider result 14 -> wb_valid_o one cycle after div_valid_i, wb_result_o = 14, dest 5, ticket 2.
- Push 5 requests with DEPTH 4 and divider busy -> req_ready_o low after the 4th; 5th held; after the first dispatch, the 5th is accepted; results return in push order.
- DIV 0xFFFFFFF9 (-7) / 2 issued while div_ready_i is held low for 3 cycles -> no enable until ready; wb_result_o = divider's 0xFFFFFFFD.
- flush_i during BUSY with 2 entries queued -> FIFO empty, no wb_valid_o for the in-flight op, no further dispatch, and the next new request dispatches normally.
- DIV_FASTPATH_EN: REM 0x1234 / 0 and DIV 0x80000000 / 0xFFFFFFFF -> no div_enable_o; wb_result_o 0x1234 then 0x80000000 on consecutive cycles.
- rst_n low mid-BUSY, with div_valid_i arriving after release -> all outputs 0 and the stale result is ignored.
